// File: rtl/lcd_char_refresh_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_char_refresh_if
// Description : Character-buffer write port and HD44780 8-bit write-only bus
//               of the LCD refresh engine, plus its status strobes.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_char_refresh_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_dat;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_db;
  logic       init_done;
  logic       frame_tick;

  // Host side: writes characters, observes the panel bus and status
  modport master (
    output wr_en, wr_addr, wr_dat,
    input  lcd_rs, lcd_rw, lcd_e, lcd_db, init_done, frame_tick
  );

  // Refresh engine side
  modport slave (
    input  wr_en, wr_addr, wr_dat,
    output lcd_rs, lcd_rw, lcd_e, lcd_db, init_done, frame_tick
  );
endinterface
`default_nettype wire

// File: rtl/lcd_char_refresh.sv
`default_nettype none
// ============================================================================
// Module      : lcd_char_refresh
// Description : 32-byte character buffer continuously refreshed onto a 16x2
//               HD44780 panel; performs power-up wait and controller init,
//               emits a one-cycle frame tick after each full screen.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_char_refresh #(
  parameter int POWERUP_CYC    = 2000000,
  parameter int E_PULSE_CYC    = 25,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 80000
) (
  input wire                clk,
  input wire                rst_n,
  lcd_char_refresh_if.slave bus
);

  // Transaction phase; r_refresh tells whether the current step is an init
  // command or a refresh slot
  localparam logic [1:0] c_PWRUP = 2'd0;
  localparam logic [1:0] c_SETUP = 2'd1;
  localparam logic [1:0] c_PULSE = 2'd2;
  localparam logic [1:0] c_WAIT  = 2'd3;

  localparam logic [5:0] c_INIT_LAST  = 6'd4;   // 0x06 entry mode
  localparam logic [5:0] c_CLEAR_STEP = 6'd3;   // 0x01 clear display
  localparam logic [5:0] c_LINE2_STEP = 6'd17;  // 0xC0 set-DDRAM line 2
  localparam logic [5:0] c_FRAME_LAST = 6'd33;  // buf[31]

  logic [1:0]  r_state;
  logic [31:0] r_cnt;
  logic        r_refresh;
  logic [5:0]  r_step;
  logic [7:0]  r_buf [32];
  logic        r_lcd_rs;
  logic        r_lcd_e;
  logic [7:0]  r_lcd_db;
  logic        r_init_done;
  logic        r_frame_tick;

  logic [31:0] w_wait_len;
  logic        w_last_init;
  logic        w_last_frame;
  logic        w_pwr_done;
  logic        w_pulse_done;
  logic        w_wait_done;
  logic        w_tick_nxt;
  logic        w_ld_refresh;
  logic [5:0]  w_ld_step;
  logic [4:0]  w_ch_idx;
  logic        w_nxt_rs;
  logic [7:0]  w_nxt_db;

  // Only the clear command needs the long post-strobe wait
  assign w_wait_len   = (!r_refresh && (r_step == c_CLEAR_STEP)) ?
                        32'(CLEAR_WAIT_CYC) : 32'(CMD_WAIT_CYC);
  assign w_last_init  = !r_refresh && (r_step == c_INIT_LAST);
  assign w_last_frame = r_refresh && (r_step == c_FRAME_LAST);
  assign w_pwr_done   = (r_cnt == 32'(POWERUP_CYC - 1));
  assign w_pulse_done = (r_cnt == 32'(E_PULSE_CYC - 1));
  assign w_wait_done  = (r_cnt == w_wait_len - 32'd1);

  // Frame tick is registered, so it is raised one cycle ahead of the final
  // WAIT cycle of the buf[31] transaction (also covers a one-cycle wait)
  assign w_tick_nxt = w_last_frame &&
                      (((r_state == c_PULSE) && w_pulse_done && (w_wait_len == 32'd1)) ||
                       ((r_state == c_WAIT) && (r_cnt + 32'd2 == w_wait_len)));

  // Which transaction gets loaded at the next SETUP
  always_comb begin
    w_ld_refresh = 1'b0;
    w_ld_step    = 6'd0;
    if (r_state != c_PWRUP) begin
      w_ld_refresh = r_refresh | w_last_init;
      w_ld_step    = (w_last_init || w_last_frame) ? 6'd0 : r_step + 6'd1;
    end
  end

  // Slots 1..16 map to buf[0..15], slots 18..33 to buf[16..31] (5-bit wrap)
  assign w_ch_idx = (w_ld_step < c_LINE2_STEP) ? (w_ld_step[4:0] - 5'd1)
                                               : (w_ld_step[4:0] - 5'd2);

  // Bus value for the next transaction; the buffer is read here, before any
  // write landing on the same edge, so a colliding write shows next frame
  always_comb begin
    w_nxt_rs = 1'b0;
    w_nxt_db = 8'h00;
    if (!w_ld_refresh) begin
      case (w_ld_step)
        6'd0:    w_nxt_db = 8'h38;
        6'd1:    w_nxt_db = 8'h38;
        6'd2:    w_nxt_db = 8'h0C;
        6'd3:    w_nxt_db = 8'h01;
        default: w_nxt_db = 8'h06;
      endcase
    end else if (w_ld_step == 6'd0) begin
      w_nxt_db = 8'h80;
    end else if (w_ld_step == c_LINE2_STEP) begin
      w_nxt_db = 8'hC0;
    end else begin
      w_nxt_rs = 1'b1;
      w_nxt_db = r_buf[w_ch_idx];
    end
  end

  // Character buffer: reset to spaces, writable in every state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
    end else if (bus.wr_en) begin
      r_buf[bus.wr_addr] <= bus.wr_dat;
    end
  end

  // Sequencer: power-up wait, then SETUP/PULSE/WAIT per bus transaction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_PWRUP;
      r_cnt        <= 32'd0;
      r_refresh    <= 1'b0;
      r_step       <= 6'd0;
      r_lcd_rs     <= 1'b0;
      r_lcd_e      <= 1'b0;
      r_lcd_db     <= 8'h00;
      r_init_done  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_tick_nxt;
      case (r_state)
        c_PWRUP: begin
          if (w_pwr_done) begin
            r_state   <= c_SETUP;
            r_cnt     <= 32'd0;
            r_refresh <= w_ld_refresh;
            r_step    <= w_ld_step;
            r_lcd_rs  <= w_nxt_rs;
            r_lcd_db  <= w_nxt_db;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        c_SETUP: begin
          r_state <= c_PULSE;
          r_lcd_e <= 1'b1;
          r_cnt   <= 32'd0;
        end
        c_PULSE: begin
          if (w_pulse_done) begin
            r_state <= c_WAIT;
            r_lcd_e <= 1'b0;
            r_cnt   <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          if (w_wait_done) begin
            r_state   <= c_SETUP;
            r_cnt     <= 32'd0;
            r_refresh <= w_ld_refresh;
            r_step    <= w_ld_step;
            r_lcd_rs  <= w_nxt_rs;
            r_lcd_db  <= w_nxt_db;
            if (w_ld_refresh && (w_ld_step == 6'd0)) r_init_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
      endcase
    end
  end

  assign bus.lcd_rs     = r_lcd_rs;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_e      = r_lcd_e;
  assign bus.lcd_db     = r_lcd_db;
  assign bus.init_done  = r_init_done;
  assign bus.frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_refresh.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lcd_char_refresh
// Description : Scoreboard bench for lcd_char_refresh. A timing model derived
//               from the transaction/frame arithmetic queues the expected bus
//               write at each SETUP; a monitor pops it on every lcd_e rise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_char_refresh;

  localparam int P     = 100;
  localparam int EP    = 4;
  localparam int CW    = 10;
  localparam int CLW   = 50;
  localparam int TX    = 1 + EP + CW;                 // 15
  localparam int FRAME = 34 * TX;                      // 510
  localparam int INIT_END = P + 4 * TX + (1 + EP + CLW); // 215

  typedef struct {
    int         cyc;
    logic       rs;
    logic [7:0] db;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;              // posedges since reset release
  logic [7:0] mbuf [32];
  exp_t exp_q [$];

  lcd_char_refresh_if bus ();

  lcd_char_refresh #(
    .POWERUP_CYC    (P),
    .E_PULSE_CYC    (EP),
    .CMD_WAIT_CYC   (CW),
    .CLEAR_WAIT_CYC (CLW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] init_cmd(input int k);
    case (k)
      0, 1:    return 8'h38;
      2:       return 8'h0C;
      3:       return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // SETUP edge of init command k: fixed-length commands, clear is the 4th
  function automatic int init_start(input int k);
    if (k <= 3) return P + TX * k;
    return P + 3 * TX + (1 + EP + CLW);
  endfunction

  // Reference model: at each SETUP edge push what the panel should receive,
  // snapshotting the model buffer before this edge's write lands
  initial begin
    exp_t e;
    foreach (mbuf[i]) mbuf[i] = 8'h20;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        cyc = 0;
        foreach (mbuf[i]) mbuf[i] = 8'h20;
        exp_q.delete();
      end else begin
        cyc++;
        e.cyc = cyc;
        if (cyc >= INIT_END) begin
          if ((cyc - INIT_END) % TX == 0) begin
            int slot;
            slot = ((cyc - INIT_END) / TX) % 34;
            if (slot == 0)       begin e.rs = 1'b0; e.db = 8'h80; end
            else if (slot == 17) begin e.rs = 1'b0; e.db = 8'hC0; end
            else if (slot < 17)  begin e.rs = 1'b1; e.db = mbuf[slot - 1]; end
            else                 begin e.rs = 1'b1; e.db = mbuf[16 + slot - 18]; end
            exp_q.push_back(e);
          end
        end else begin
          for (int k = 0; k < 5; k++) begin
            if (cyc == init_start(k)) begin
              e.rs = 1'b0;
              e.db = init_cmd(k);
              exp_q.push_back(e);
            end
          end
        end
        if (bus.wr_en) mbuf[bus.wr_addr] = bus.wr_dat;
      end
    end
  end

  // Monitor: status strobes every cycle, bus transactions on each lcd_e pulse
  initial begin
    logic       prev_e;
    int         rise_cyc;
    logic       rise_rs;
    logic [7:0] rise_db;
    exp_t       e;
    prev_e = 1'b0;
    rise_cyc = 0;
    rise_rs = 1'b0;
    rise_db = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_e = 1'b0;
      end else begin
        chk("init_done", 32'(bus.init_done), 32'(cyc >= INIT_END));
        chk("frame_tick", 32'(bus.frame_tick),
            32'((cyc >= INIT_END) && ((cyc - INIT_END) % FRAME == FRAME - 1)));
        chk("lcd_rw", 32'(bus.lcd_rw), 32'd0);
        if (bus.lcd_e && !prev_e) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_start_cycle", 32'(cyc), 32'(e.cyc + 1));
            chk("lcd_rs", 32'(bus.lcd_rs), 32'(e.rs));
            chk("lcd_db", 32'(bus.lcd_db), 32'(e.db));
          end
          rise_cyc = cyc;
          rise_rs  = bus.lcd_rs;
          rise_db  = bus.lcd_db;
        end
        if (!bus.lcd_e && prev_e) begin
          chk("pulse_width", 32'(cyc - rise_cyc), 32'(EP));
          chk("rs_stable", 32'(bus.lcd_rs), 32'(rise_rs));
          chk("db_stable", 32'(bus.lcd_db), 32'(rise_db));
        end
        if (exp_q.size() > 0 && exp_q[0].cyc + 1 < cyc) begin
          chk("missing_pulse", 32'(exp_q[0].cyc), 32'hFFFF_FFFF);
          void'(exp_q.pop_front());
        end
        prev_e = bus.lcd_e;
      end
    end
  end

  task automatic wait_ticks(input int n, input bit jiggle);
    int seen;
    int budget;
    seen = 0;
    budget = INIT_END + FRAME * n + 100;
    while (seen < n && budget > 0) begin
      @(negedge clk);
      if (jiggle) begin
        bus.wr_dat  = 8'($urandom);
        bus.wr_addr = 5'($urandom);
      end
      if (bus.frame_tick) seen++;
      budget--;
    end
    if (seen < n) chk("frame_tick_timeout", 32'(seen), 32'(n));
  endtask

  task automatic write1(input logic [4:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_dat  = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_lcd_rs", 32'(bus.lcd_rs), 32'd0);
    chk("rst_lcd_rw", 32'(bus.lcd_rw), 32'd0);
    chk("rst_lcd_e", 32'(bus.lcd_e), 32'd0);
    chk("rst_lcd_db", 32'(bus.lcd_db), 32'd0);
    chk("rst_init_done", 32'(bus.init_done), 32'd0);
    chk("rst_frame_tick", 32'(bus.frame_tick), 32'd0);
  endtask

  // Stimulus
  initial begin
    int budget;
    bus.wr_en   = 1'b0;
    bus.wr_addr = 5'd0;
    bus.wr_dat  = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;

    // Idle power-up, init and two blank frames; wr_dat/wr_addr churn with wr_en low
    wait_ticks(2, 1'b1);

    // Reset while strobing a data character
    budget = 1200;
    while (!(bus.lcd_e && bus.lcd_rs) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) chk("data_pulse_timeout", 32'd0, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs();
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;

    // Writes during the replayed init appear in the first frame
    repeat (10) @(negedge clk);
    write1(5'd0, 8'h58);
    write1(5'd1, 8'h3A);
    write1(5'd16, 8'h59);
    wait_ticks(1, 1'b0);

    // Collision: write char 5 during its own SETUP cycle (slot 6 of the frame)
    repeat (1 + 6 * TX) @(negedge clk);
    chk("collision_setup_rs", 32'(bus.lcd_rs), 32'd1);
    chk("collision_setup_e", 32'(bus.lcd_e), 32'd0);
    chk("collision_setup_db", 32'(bus.lcd_db), 32'h20);
    write1(5'd5, 8'h41);
    wait_ticks(2, 1'b0);

    // Back-to-back fill of the whole buffer
    for (int a = 0; a < 32; a++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'(a);
      bus.wr_dat  = 8'(8'h30 + (a % 10));
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    wait_ticks(2, 1'b0);

    // Random traffic
    for (int i = 0; i < 80; i++) begin
      bus.wr_en   = 1'($urandom_range(0, 1));
      bus.wr_addr = 5'($urandom);
      bus.wr_dat  = 8'($urandom);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    wait_ticks(2, 1'b0);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
